wb_stage_multi: RTL
===================

# wb_stage_multi

Parametrised multi-channel write-back stage that sits between the memory stage and the register file. Each of NUM_CH channels carries one instruction per cycle. For each channel the block:
- selects the write-back source;
- extracts and extends load data;
- suppresses x0 writes and same-cycle write-after-write losers;
- drives one register-file write port.

Unlike the single-channel combinational stage, outputs are registered, the stage supports hold/flush from the hazard unit, and it keeps a retired-instruction counter.

## Interface
- BUS_W, default 32: datapath width. Legal values are 32 or 64.
- NUM_CH, default 2: number of parallel write-back channels, 1..4.
- CNT_W, default 64: width of the retired-instruction counter.

Clock and reset are one clock; reset is asynchronous and active-high.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- holdIn  in  1  freeze the stage register.
- flushIn  in  1  discard the incoming and held contents.
- chValidIn  in  NUM_CH  the channel carries a real instruction.
- wdOpIn  in  8*NUM_CH  per channel: [0] write enable, [2:1] source select, [7:3] rd.
- memSizeIn  in  3*NUM_CH  per channel load funct3.
- memAddrLoIn  in  2*NUM_CH  per channel load address bits [1:0].
- pcPlusIn, exResultIn, memResultIn, immIn  in  BUS_W*NUM_CH each  per-channel candidate results.
- regAddrOut  out  5*NUM_CH  register-file write address.
- regWeOut  out  NUM_CH  register-file write enable.
- regWDataOut  out  BUS_W*NUM_CH  register-file write data.
- retiredCountOut  out  CNT_W  number of instructions retired so far.

Channel c occupies slice [c*W +: W] of each flattened bus. A higher index means a younger instruction in program order.

## Operation
Source select, per channel, uses wdOp[2:1]:
- 00: exResult.
- 01: load data, after extraction.
- 10: imm.
- 11: pcPlus.

Load extraction applies only when the select is 01. It works on the low 32 bits of memResult. Results are sign- or zero-extended to BUS_W.
- 000 lb: byte at lane memAddrLo, sign-extended.
- 100 lbu: byte at lane memAddrLo, zero-extended.
- 001 lh: halfword at memAddrLo[1], sign-extended; memAddrLo[0] is ignored.
- 101 lhu: halfword at memAddrLo[1], zero-extended; memAddrLo[0] is ignored.
- 010 lw: low word, sign-extended to BUS_W.
- 110 lwu: low word, zero-extended.
- 011 ld: memResult passed unmodified.
- 111: memResult passed unmodified (reserved).

Write enable, per channel:
- Raw enable is chValid AND wdOp[0] AND (rd != 0).
- WAW rule: a channel's enable is cleared if any higher-index channel has a raw enable with the same rd. Only the youngest writer survives.
- When a channel's final enable is 0, its regAddrOut and regWDataOut are driven 0.

Retired counter:
- Adds popcount(chValidIn) on every capture.
- This counts x0 writes, non-writing instructions and WAW losers.
- Wraps modulo 2^CNT_W.

## Timing
Stage register update, with priority in this order:
- rst asserted: all outputs go to 0 immediately (asynchronous). This covers regAddrOut, regWeOut, regWDataOut and retiredCountOut.
- flushIn=1: output registers load 0 at the next edge and the counter is unchanged. flushIn has priority over holdIn.
- holdIn=1, flushIn=0: output registers and counter keep their values. regWeOut stays asserted if it already was. Rewriting the same value is harmless.
- Otherwise the block captures: the outputs computed from the current inputs are registered and the counter is updated.

Other timing rules:
- Latency is exactly 1 cycle from inputs to register-file write signals. There is no combinational path from inputs to outputs.
- A capture with chValidIn=0 drives all enables to 0 and leaves the counter unchanged.
- Releasing rst mid-stream: the first edge after release is an ordinary capture. No stale data survives reset.
- Counter wrap: at 2^CNT_W-1, adding 2 gives 1. The benches use CNT_W=8 to exercise this.

## Test plan
1. Load extraction, BUS_W=32, NUM_CH=1, memResult=0x80FF7F01, sel=01, rd=5. Required values one cycle later:
   - lb, lane 3: 0xFFFFFF80.
   - lbu, lane 1: 0x0000007F.
   - lh, addrLo=2: 0xFFFF80FF.
   - lhu, addrLo=3: 0x000080FF.
   - lw: 0x80FF7F01.
2. Source select, NUM_CH=2. Channel 0: sel=00, ex=0x11, rd=1. Channel 1: sel=11, pcPlus=0x104, rd=2. Required: weOut=11, addr {2,1}, data {0x104, 0x11}, counter +2.
3. WAW and x0:
   - Both channels target rd=7. Required: only channel 1 write-enabled; channel 0 outputs are 0.
   - Channel 0 targets rd=0, wdOp[0]=1. Required: weOut[0]=0 and the counter still increments.
4. Hold and flush. Capture a valid write, then assert holdIn for 3 cycles while changing the inputs. Required: outputs are unchanged for those 3 cycles, then update on release.
   - holdIn and flushIn together: outputs are 0 next cycle and the counter is unchanged.
5. Asynchronous reset. Assert rst between edges while weOut=1. Required: all outputs are 0 before the next edge and the counter is 0.
6. Counter wrap, CNT_W=8. Preload to 255 by streaming captures, then one capture with chValidIn=11. Required: retiredCountOut=1.

Source files
------------

// File: rtl/wb_stage_multi.sv
// Multi-channel registered write-back stage: source select, load
// extension, x0/WAW write suppression and retired-instruction count.
module wb_stage_multi #(
  parameter int BUS_W  = 32,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    holdIn,
  input  logic                    flushIn,
  input  logic [NUM_CH-1:0]       chValidIn,
  input  logic [8*NUM_CH-1:0]     wdOpIn,
  input  logic [3*NUM_CH-1:0]     memSizeIn,
  input  logic [2*NUM_CH-1:0]     memAddrLoIn,
  input  logic [BUS_W*NUM_CH-1:0] pcPlusIn,
  input  logic [BUS_W*NUM_CH-1:0] exResultIn,
  input  logic [BUS_W*NUM_CH-1:0] memResultIn,
  input  logic [BUS_W*NUM_CH-1:0] immIn,
  output logic [5*NUM_CH-1:0]     regAddrOut,
  output logic [NUM_CH-1:0]       regWeOut,
  output logic [BUS_W*NUM_CH-1:0] regWDataOut,
  output logic [CNT_W-1:0]        retiredCountOut
);

  function automatic logic [BUS_W-1:0] ext_load(
    input logic [BUS_W-1:0] m,
    input logic [2:0]       sz,
    input logic [1:0]       lo
  );
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    logic [BUS_W-1:0] r;
    w = m[31:0];
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    unique case (sz)
      3'b000:  r = BUS_W'($signed(b));
      3'b100:  r = BUS_W'(b);
      3'b001:  r = BUS_W'($signed(h));
      3'b101:  r = BUS_W'(h);
      3'b010:  r = BUS_W'($signed(w));
      3'b110:  r = BUS_W'(w);
      default: r = m;
    endcase
    return r;
  endfunction

  logic [5*NUM_CH-1:0]     addr_d, addr_q;
  logic [NUM_CH-1:0]       we_d, we_q;
  logic [BUS_W*NUM_CH-1:0] data_d, data_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;

  logic [NUM_CH-1:0] raw;
  logic [4:0]        rd [NUM_CH];
  logic [BUS_W-1:0]  res;
  logic [7:0]        op;

  always_comb begin
    raw    = '0;
    we_d   = '0;
    addr_d = '0;
    data_d = '0;
    cnt_d  = cnt_q;
    res    = '0;
    op     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      op    = wdOpIn[c*8 +: 8];
      rd[c] = op[7:3];
      raw[c] = chValidIn[c] & op[0] & (op[7:3] != 5'd0);
      cnt_d  = cnt_d + CNT_W'(chValidIn[c]);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      op = wdOpIn[c*8 +: 8];
      unique case (op[2:1])
        2'b00: res = exResultIn[c*BUS_W +: BUS_W];
        2'b01: res = ext_load(
                 memResultIn[c*BUS_W +: BUS_W],
                 memSizeIn[c*3 +: 3],
                 memAddrLoIn[c*2 +: 2]);
        2'b10: res = immIn[c*BUS_W +: BUS_W];
        default: res = pcPlusIn[c*BUS_W +: BUS_W];
      endcase
      we_d[c] = raw[c];
      // Younger channels win a same-rd race.
      for (int j = c + 1; j < NUM_CH; j++)
        if (raw[j] && rd[j] == rd[c])
          we_d[c] = 1'b0;
      if (we_d[c]) begin
        addr_d[c*5 +: 5]         = rd[c];
        data_d[c*BUS_W +: BUS_W] = res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      we_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (flushIn) begin
      addr_q <= '0;
      we_q   <= '0;
      data_q <= '0;
    end else if (!holdIn) begin
      addr_q <= addr_d;
      we_q   <= we_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign regAddrOut      = addr_q;
  assign regWeOut        = we_q;
  assign regWDataOut     = data_q;
  assign retiredCountOut = cnt_q;

endmodule
